// File: rtl/alu_out_collector.sv
// Collects finished ALU results from two units into a small FWFT FIFO.
// Round-robin arbitration feeds the FIFO. A valid/ready port drains it.
module alu_out_collector #(
  parameter  int unsigned DATA_SIZE = 16,
  parameter  int unsigned ID_SIZE   = 8,
  parameter  int unsigned DEPTH     = 4,
  localparam int unsigned RES_SIZE  = DATA_SIZE + 1 + ID_SIZE,
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RES_SIZE-1:0] res_0,
  input  logic                valid_0,
  output logic                written_0,
  input  logic [RES_SIZE-1:0] res_1,
  input  logic                valid_1,
  output logic                written_1,
  output logic                ready_f_res,
  output logic [RES_SIZE-1:0] out_data,
  output logic                out_src,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [RES_SIZE:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               last_grant;

  logic               full_c;
  logic               elig_0_c;
  logic               elig_1_c;
  logic               grant_0_c;
  logic               grant_1_c;
  logic               push_c;
  logic               pop_c;
  logic [RES_SIZE:0]  wdata_c;

  // Status flags and the FIFO head are decoded from registers only.
  assign full_c      = (count == CNT_W'(DEPTH));
  assign ready_f_res = !full_c;
  assign out_valid   = (count != '0);
  assign out_data    = mem[rd_ptr][RES_SIZE-1:0];
  assign out_src     = mem[rd_ptr][RES_SIZE];

  // A source is masked while its written pulse is high, so it is never granted twice in a row.
  always_comb begin
    elig_0_c  = valid_0 && !written_0;
    elig_1_c  = valid_1 && !written_1;
    grant_0_c = 1'b0;
    grant_1_c = 1'b0;
    if (!full_c) begin
      if (elig_0_c && elig_1_c) begin
        grant_0_c = last_grant;
        grant_1_c = !last_grant;
      end else begin
        grant_0_c = elig_0_c;
        grant_1_c = elig_1_c;
      end
    end
    push_c  = grant_0_c || grant_1_c;
    pop_c   = out_valid && out_ready;
    wdata_c = grant_1_c ? {1'b1, res_1} : {1'b0, res_0};
  end

  // Control state: pointers, occupancy, arbitration history and written pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      written_0  <= 1'b0;
      written_1  <= 1'b0;
    end else begin
      written_0 <= grant_0_c;
      written_1 <= grant_1_c;
      if (push_c) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        last_grant <= grant_1_c;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset. Occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      mem[wr_ptr] <= wdata_c;
    end
  end

endmodule

// File: tb/tb_alu_out_collector.sv
// Scoreboard bench for alu_out_collector. A reference model predicts grants, pulses and occupancy.
// The FIFO head is compared against the expected-order queue.
module tb_alu_out_collector;

  localparam int unsigned DS = 16;
  localparam int unsigned IS = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned RS = DS + 1 + IS;
  localparam int unsigned CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RS-1:0] res_0 = '0;
  logic [RS-1:0] res_1 = '0;
  logic          valid_0 = 1'b0;
  logic          valid_1 = 1'b0;
  logic          written_0;
  logic          written_1;
  logic          ready_f_res;
  logic [RS-1:0] out_data;
  logic          out_src;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;

  alu_out_collector #(.DATA_SIZE(DS), .ID_SIZE(IS), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .res_0(res_0), .valid_0(valid_0), .written_0(written_0),
    .res_1(res_1), .valid_1(valid_1), .written_1(written_1),
    .ready_f_res(ready_f_res),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [RS-1:0] sq0 [$];
  logic [RS-1:0] sq1 [$];
  logic [RS:0]   sb  [$];
  int            m_count = 0;
  logic          m_last  = 1'b1;
  logic          m_wr0   = 1'b0;
  logic          m_wr1   = 1'b0;
  int            next_id = 0;

  task automatic check_eq(input string tag, input logic [RS:0] got, input logic [RS:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [RS-1:0] mk(input int id, input logic c, input int data);
    return {IS'(id), c, DS'(data)};
  endfunction

  // One clock: drive sources, predict the edge, then compare the DUT against the model.
  task automatic step(input logic rst_v);
    logic e0, e1, g0, g1, pop;
    logic [RS-1:0] r0, r1;
    rst     = rst_v;
    valid_0 = (sq0.size() != 0);
    valid_1 = (sq1.size() != 0);
    r0      = valid_0 ? sq0[0] : '0;
    r1      = valid_1 ? sq1[0] : '0;
    res_0   = r0;
    res_1   = r1;
    e0  = valid_0 && !m_wr0;
    e1  = valid_1 && !m_wr1;
    g0  = (m_count < int'(D)) && e0 && (!e1 || m_last);
    g1  = (m_count < int'(D)) && e1 && (!e0 || !m_last);
    pop = (m_count != 0) && out_ready;
    @(posedge clk);
    #1;
    if (rst_v) begin
      m_count = 0; m_last = 1'b1; m_wr0 = 1'b0; m_wr1 = 1'b0;
      sb.delete(); sq0.delete(); sq1.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (g0) begin sb.push_back({1'b0, r0}); void'(sq0.pop_front()); m_last = 1'b0; end
      if (g1) begin sb.push_back({1'b1, r1}); void'(sq1.pop_front()); m_last = 1'b1; end
      m_count = m_count + int'(g0 || g1) - int'(pop);
      m_wr0 = g0;
      m_wr1 = g1;
    end
    check_eq("count",     (RS+1)'(count),       (RS+1)'(m_count));
    check_eq("written_0", (RS+1)'(written_0),   (RS+1)'(m_wr0));
    check_eq("written_1", (RS+1)'(written_1),   (RS+1)'(m_wr1));
    check_eq("out_valid", (RS+1)'(out_valid),   (RS+1)'(m_count != 0));
    check_eq("ready",     (RS+1)'(ready_f_res), (RS+1)'(m_count != int'(D)));
    if (sb.size() != 0) check_eq("head", {out_src, out_data}, sb[0]);
  endtask

  initial begin
    // Reset state
    step(1'b1);
    step(1'b1);
    check_eq("rst_count", (RS+1)'(count), '0);
    check_eq("rst_ready", (RS+1)'(ready_f_res), (RS+1)'(1));

    // Single result latency
    sq0.push_back(25'h751234);
    step(1'b0);
    check_eq("t1_data", (RS+1)'(out_data), (RS+1)'(25'h751234));
    check_eq("t1_src",  (RS+1)'(out_src), '0);
    check_eq("t1_wr0",  (RS+1)'(written_0), (RS+1)'(1));
    step(1'b0);
    check_eq("t1_wr0_end", (RS+1)'(written_0), '0);
    out_ready = 1'b1;
    step(1'b0);

    // Both sources contending with a draining consumer: grants alternate
    step(1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sq0.push_back(mk(16 + i, 1'b0, 16'hA000 + i));
      sq1.push_back(mk(32 + i, 1'b1, 16'hB000 + i));
    end
    step(1'b0);
    check_eq("t2_first_src", (RS+1)'(out_src), '0);
    step(1'b0);
    check_eq("t2_second_src", (RS+1)'(out_src), (RS+1)'(1));
    for (int i = 0; i < 10; i++) step(1'b0);

    // Fill to full, pending fifth result, single pop
    step(1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sq0.push_back(mk(48 + i, 1'b0, 16'h0C00 + i));
      sq1.push_back(mk(56 + i, 1'b1, 16'h0D00 + i));
    end
    sq1.push_back(mk(60, 1'b1, 16'h0DFF));
    for (int i = 0; i < 8; i++) step(1'b0);
    check_eq("t3_full_count", (RS+1)'(count), (RS+1)'(4));
    check_eq("t3_full_ready", (RS+1)'(ready_f_res), '0);
    check_eq("t3_pending_wr1", (RS+1)'(written_1), '0);
    out_ready = 1'b1;
    step(1'b0);
    out_ready = 1'b0;
    check_eq("t3_after_pop", (RS+1)'(count), (RS+1)'(3));
    step(1'b0);
    check_eq("t3_refill", (RS+1)'(count), (RS+1)'(4));

    // Full with pop and new valid in the same cycle: pop only
    sq0.push_back(mk(70, 1'b1, 16'hFFFF));
    out_ready = 1'b1;
    step(1'b0);
    out_ready = 1'b0;
    check_eq("t4_pop_only", (RS+1)'(count), (RS+1)'(3));
    check_eq("t4_no_wr0", (RS+1)'(written_0), '0);
    step(1'b0);
    check_eq("t4_push_next", (RS+1)'(count), (RS+1)'(4));
    check_eq("t4_wr0", (RS+1)'(written_0), (RS+1)'(1));

    // Pointer wrap with ten ordered IDs
    step(1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) sq0.push_back(mk(i, i[0], 16'h5000 + i));
    next_id = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid && out_ready) begin
        check_eq("t5_id", (RS+1)'(out_data[RS-1 -: IS]), (RS+1)'(next_id));
        next_id++;
      end
      step(1'b0);
    end
    check_eq("t5_total", (RS+1)'(next_id), (RS+1)'(10));

    // Reset with count=3 and written_1 high
    step(1'b1);
    out_ready = 1'b0;
    sq0.push_back(mk(80, 1'b0, 16'h1111));
    sq1.push_back(mk(81, 1'b1, 16'h2222));
    sq1.push_back(mk(82, 1'b1, 16'h3333));
    for (int i = 0; i < 4; i++) step(1'b0);
    check_eq("t6_pre_count", (RS+1)'(count), (RS+1)'(3));
    check_eq("t6_pre_wr1", (RS+1)'(written_1), (RS+1)'(1));
    step(1'b1);
    check_eq("t6_count", (RS+1)'(count), '0);
    check_eq("t6_valid", (RS+1)'(out_valid), '0);
    check_eq("t6_wr1", (RS+1)'(written_1), '0);
    check_eq("t6_ready", (RS+1)'(ready_f_res), (RS+1)'(1));
    step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
